uart_tx_serializer: RTL and testbench

- UART transmit serializer placed between the TX FIFO and the uart_txd pin.
- Runs on uart_clk, which is 16x the baud rate; for example, 153.6 kHz for 9600 baud.
- Whenever the FIFO is non-empty it pops one byte and sends an 8N1 frame, LSB first, with every bit held for 16 uart_clk cycles.
- Frames are sent back-to-back while data remains; the line idles high.

---
 rtl/uart_tx_serializer_pkg.sv | 31 +++
 rtl/uart_tx_serializer_baud_tick.sv | 41 ++++
 rtl/uart_tx_serializer.sv | 158 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART TX serializer.
//            The PARITY state exists in the enum but is only reachable
//            when UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_OVERSAMPLE = 16;
    localparam int c_DATA_BITS  = 8;
    localparam int c_STOP_BITS  = 1;

    localparam logic c_IDLE_LVL  = 1'b1;
    localparam logic c_START_LVL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer_baud_tick.sv
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Oversample tick counter; pulses o_bit_done on the last cycle of
//            every OVERSAMPLE-cycle bit period. Cleared by i_restart.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = c_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_bit_done
);

    localparam int                  c_TICK_W   = $clog2(OVERSAMPLE);
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(OVERSAMPLE - 1);

    logic [c_TICK_W-1:0] r_tick;
    logic                w_at_max;

    assign w_at_max = (r_tick == c_TICK_MAX);

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_tick <= '0;
        end else if (i_enable) begin
            r_tick <= w_at_max ? '0 : r_tick + 1'b1;
        end
    end

    assign o_bit_done = i_enable && w_at_max;

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : Pops bytes from a non-show-ahead TX FIFO and serializes them as
//            8N1 frames (8E1 when UART_TX_PARITY_EN is defined), LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = c_OVERSAMPLE,
    parameter int DATA_BITS  = c_DATA_BITS,
    parameter int STOP_BITS  = c_STOP_BITS
) (
    input  logic                 uart_clk,
    input  logic                 rst_n,
    input  logic                 tf_empty,
    input  logic [DATA_BITS-1:0] tf_data,
    output logic                 tf_rdreq,
    output logic                 uart_txd
);

    localparam int                 c_BIT_W     = $clog2(DATA_BITS);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shreg;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic                 r_txd;
    logic                 r_rdreq;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_bit_done;
    logic w_tick_restart;
    logic w_tick_enable;

    // The bit period starts on the LOAD edge, the same edge the start level is driven.
    assign w_tick_restart = (r_state == LOAD);
    assign w_tick_enable  = (r_state == START) || (r_state == DATA) ||
                            (r_state == PARITY) || (r_state == STOP);

    uart_baud_tick #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk        (uart_clk),
        .rst        (rst_n),
        .i_restart  (w_tick_restart),
        .i_enable   (w_tick_enable),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge uart_clk) begin
        if (rst_n) begin
            r_state   <= IDLE;
            r_txd     <= c_IDLE_LVL;
            r_rdreq   <= 1'b0;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_rdreq <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_txd <= c_IDLE_LVL;
                    if (!tf_empty) begin
                        r_state <= READ;
                        r_rdreq <= 1'b1;
                    end
                end

                READ: begin
                    r_state <= LOAD;
                end

                // FIFO read data is valid here, one cycle after the strobe.
                LOAD: begin
                    r_shreg   <= tf_data;
`ifdef UART_TX_PARITY_EN
                    r_parity  <= ^tf_data;
`endif
                    r_txd     <= c_START_LVL;
                    r_bit_cnt <= '0;
                    r_state   <= START;
                end

                START: begin
                    if (w_bit_done) begin
                        r_txd   <= r_shreg[0];
                        r_shreg <= r_shreg >> 1;
                        r_state <= DATA;
                    end
                end

                DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_cnt == c_LAST_DATA) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_txd     <= r_parity;
                            r_state   <= PARITY;
`else
                            r_txd     <= c_IDLE_LVL;
                            r_state   <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_txd     <= r_shreg[0];
                            r_shreg   <= r_shreg >> 1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_done) begin
                        r_txd   <= c_IDLE_LVL;
                        r_state <= STOP;
                    end
                end
`endif

                // Chaining straight into READ keeps the inter-frame gap at two cycles.
                STOP: begin
                    if (w_bit_done) begin
                        if (r_bit_cnt == c_LAST_STOP) begin
                            r_bit_cnt <= '0;
                            if (!tf_empty) begin
                                r_state <= READ;
                                r_rdreq <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_txd   <= c_IDLE_LVL;
                end
            endcase
        end
    end

    assign uart_txd = r_txd;
    assign tf_rdreq = r_rdreq;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// Module   : tb_uart_tx_serializer
// Brief    : Directed self-checking bench for uart_tx_serializer with a
//            non-show-ahead FIFO model. Honors UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_serializer;

    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB        = 11;
    localparam int FRAME_CYC = 176;
    localparam logic [10:0] E55 = 11'b01010101001;
    localparam logic [10:0] EA5 = 11'b01010010101;
    localparam logic [10:0] E0F = 11'b01111000001;
    localparam logic [10:0] E00 = 11'b00000000001;
    localparam logic [10:0] E07 = 11'b01110000011;
`else
    localparam int NB        = 10;
    localparam int FRAME_CYC = 160;
    localparam logic [10:0] E55 = 11'b00101010101;
    localparam logic [10:0] EA5 = 11'b00101001011;
    localparam logic [10:0] E0F = 11'b00111100001;
    localparam logic [10:0] E00 = 11'b00000000001;
    localparam logic [10:0] E07 = 11'b00111000001;
`endif
    localparam int FRAME = NB * OS;

    logic       uart_clk = 1'b0;
    logic       rst_n    = 1'b1;
    logic       tf_empty = 1'b1;
    logic [7:0] tf_data  = 8'h00;
    logic       tf_rdreq;
    logic       uart_txd;

    uart_tx_serializer dut (
        .uart_clk (uart_clk),
        .rst_n    (rst_n),
        .tf_empty (tf_empty),
        .tf_data  (tf_data),
        .tf_rdreq (tf_rdreq),
        .uart_txd (uart_txd)
    );

    always #5 uart_clk = ~uart_clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic       line[$];
    logic       rdq[$];
    logic [7:0] fq[$];
    logic       glitch = 1'b0;
    logic       poison = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: FIFO pops on an edge that sees rdreq, outputs sampled on negedge.
    task automatic tick();
        logic rd_pre;
        rd_pre = tf_rdreq;
        @(posedge uart_clk);
        #1;
        if (rd_pre && fq.size() > 0) tf_data = fq.pop_front();
        if (poison) tf_data = 8'hFF;
        tf_empty = (fq.size() == 0) && !glitch;
        @(negedge uart_clk);
        line.push_back(uart_txd);
        rdq.push_back(tf_rdreq);
        cyc++;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        tf_empty = 1'b0;
    endtask

    function automatic int count_rd(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) if (rdq[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int all_high(input int a, input int b);
        for (int i = a; i < b; i++) if (line[i] !== 1'b1) return 0;
        return 1;
    endfunction

    function automatic int find_start(input int from);
        for (int i = from; i < line.size(); i++)
            if (line[i-1] === 1'b1 && line[i] === 1'b0) return i;
        return -1;
    endfunction

    // Each bit must hold one level for all OS samples; a broken bit reports 2.
    task automatic check_frame(input string tag, input int st, input logic [10:0] exp);
        for (int b = 0; b < NB; b++) begin
            logic [31:0] obs;
            obs = {31'b0, line[st + b*OS]};
            for (int s = 1; s < OS; s++)
                if (line[st + b*OS + s] !== line[st + b*OS]) obs = 32'd2;
            check_eq($sformatf("%s_bit%0d", tag, b), obs, {31'b0, exp[NB-1-b]});
        end
    endtask

    initial begin
        int p, st, s2, n;
        @(negedge uart_clk);

        // Reset held with an empty FIFO, then released.
        repeat (5) tick();
        check_eq("rst_txd_high", all_high(0, 5), 1);
        check_eq("rst_no_rdreq", count_rd(0, 5), 0);
        rst_n = 1'b0;
        repeat (20) tick();
        check_eq("idle_no_rdreq", count_rd(5, 25), 0);
        check_eq("idle_line_high", all_high(5, 25), 1);

        // Single byte 0x55: strobe the cycle after the sampling edge, start two later.
        push(8'h55);
        p = cyc;
        repeat (FRAME + 30) tick();
        check_eq("t1_rdreq_lat", rdq[p], 1);
        check_eq("t1_read_line_high", line[p+1], 1);
        check_frame("t1", p + 2, E55);
        check_eq("t1_rdreq_count", count_rd(p, cyc), 1);
        check_eq("t1_idle_after", all_high(p + 2 + FRAME, cyc), 1);

        // Back-to-back 0xA5, 0x0F.
        push(8'hA5);
        push(8'h0F);
        p  = cyc;
        st = p + 2;
        s2 = st + FRAME + 2;
        repeat (2*FRAME + 30) tick();
        check_frame("t2a", st, EA5);
        check_eq("t2_second_rdreq", rdq[st + FRAME], 1);
        check_eq("t2_gap_high", all_high(st + FRAME, s2), 1);
        check_frame("t2b", s2, E0F);
        check_eq("t2_rdreq_count", count_rd(p, cyc), 2);

        // 0x00 frame with tf_data forced to 0xFF and tf_empty toggling mid-frame.
        push(8'h00);
        p  = cyc;
        st = p + 2;
        repeat (20) tick();
        poison = 1'b1;
        for (int i = 0; i < 60; i++) begin
            glitch = ((i % 5) < 2);
            tick();
        end
        glitch = 1'b0;
        repeat (FRAME) tick();
        poison = 1'b0;
        check_frame("t3", st, E00);
        check_eq("t3_rdreq_count", count_rd(p, cyc), 1);

        // Reset during data bit 3 of a 0x00 frame.
        push(8'h00);
        p  = cyc;
        st = p + 2;
        while (cyc < st + 70) tick();
        check_eq("t4_bit3_low", line[st+69], 0);
        rst_n = 1'b1;
        tick();
        check_eq("t4_rst_line_high", line[cyc-1], 1);
        check_eq("t4_rst_rdreq_low", rdq[cyc-1], 0);
        repeat (3) tick();
        rst_n = 1'b0;
        n = cyc;
        repeat (20) tick();
        check_eq("t4_quiet_after_rst", count_rd(n, cyc), 0);
        push(8'h0F);
        p = cyc;
        repeat (FRAME + 30) tick();
        check_eq("t4_new_rdreq", rdq[p], 1);
        check_frame("t4_new", p + 2, E0F);

        // 0x07 twice: parity bit (if enabled) and start-to-start period.
        push(8'h07);
        push(8'h07);
        p  = cyc;
        st = p + 2;
        repeat (2*FRAME + 30) tick();
        check_frame("t5", st, E07);
        s2 = find_start(st + (NB-1)*OS);
        check_eq("t5_frame_period", s2 - st, FRAME_CYC + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
